// File: rtl/cache_request_queue_pkg.sv
// Shared opcodes, hit/miss encoding, queue FSM states and a log2 helper
// for the cache request queue.
package cache_request_queue_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic HIT  = 1'b1;
  localparam logic MISS = 1'b0;

  localparam logic [0:0] QREQ_IDLE = 1'b0;
  localparam logic [0:0] QREQ_WAIT = 1'b1;

  // Ceiling log2, usable in parameter defaults.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/cache_req_fifo.sv
// Synchronous FIFO holding packed request vectors; exposes count/full/empty.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module cache_req_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push, w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cache_request_queue.sv
// Request queue in front of the cache: buffers requests, issues one at a time
// and returns a one-cycle response. CACHE_REQ_TIMEOUT_EN adds a WAIT timeout.
module cache_request_queue
  import cache_request_queue_pkg::*;
#(
  parameter int CACHE_TAG_WIDTH  = 4,
  parameter int CACHE_DATA_WIDTH = 4,
  parameter int OPCODE_WIDTH     = 2,
  parameter int CACHE_LINE_WIDTH = OPCODE_WIDTH + CACHE_TAG_WIDTH + CACHE_DATA_WIDTH,
  parameter int QUEUE_DEPTH      = 4,
  parameter int QUEUE_PTR_WIDTH  = log2(QUEUE_DEPTH),
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [OPCODE_WIDTH-1:0]     req_opcode,
  input  logic [CACHE_TAG_WIDTH-1:0]  req_tag,
  input  logic [CACHE_DATA_WIDTH-1:0] req_data,
  output logic [CACHE_LINE_WIDTH-1:0] cache_vector_out,
  input  logic                        cache_ack,
  input  logic                        cache_hit_miss,
  input  logic [CACHE_DATA_WIDTH-1:0] cache_data,
  output logic                        resp_valid,
  output logic                        resp_hit,
  output logic [CACHE_TAG_WIDTH-1:0]  resp_tag,
  output logic [CACHE_DATA_WIDTH-1:0] resp_data,
  output logic [QUEUE_PTR_WIDTH:0]    queue_count,
  output logic                        timeout_err
);

  localparam logic [CACHE_LINE_WIDTH-1:0] NOP_VEC =
    {OPCODE_WIDTH'(OP_NOP), {(CACHE_TAG_WIDTH + CACHE_DATA_WIDTH){1'b0}}};

  logic [0:0]                  r_state;
  logic [CACHE_LINE_WIDTH-1:0] r_vec;
  logic                        r_resp_valid, r_resp_hit;
  logic [CACHE_TAG_WIDTH-1:0]  r_resp_tag;
  logic [CACHE_DATA_WIDTH-1:0] r_resp_data;

  logic                        w_full, w_empty, w_push, w_pop, w_expire;
  logic [CACHE_LINE_WIDTH-1:0] w_head;
  logic [CACHE_TAG_WIDTH-1:0]  w_issue_tag;

  // Ready comes only from registered occupancy; NOPs are acknowledged but dropped.
  assign req_ready   = !w_full;
  assign w_push      = req_valid && !w_full && (req_opcode != OPCODE_WIDTH'(OP_NOP));
  assign w_pop       = (r_state == QREQ_IDLE) && !w_empty;
  assign w_issue_tag = r_vec[CACHE_DATA_WIDTH +: CACHE_TAG_WIDTH];

  cache_req_fifo #(
    .WIDTH (CACHE_LINE_WIDTH),
    .DEPTH (QUEUE_DEPTH),
    .PTR_W (QUEUE_PTR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({req_opcode, req_tag, req_data}),
    .dout  (w_head),
    .count (queue_count),
    .full  (w_full),
    .empty (w_empty)
  );

`ifdef CACHE_REQ_TIMEOUT_EN
  localparam int TW = log2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_tcnt;
  logic          r_timeout_err;

  // Expiry on the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle ack wins.
  assign w_expire = (r_state == QREQ_WAIT) && !cache_ack &&
                    (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_pop)                     r_tcnt <= '0;
      else if (r_state == QREQ_WAIT) r_tcnt <= r_tcnt + 1'b1;
      if (w_expire) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= QREQ_IDLE;
      r_vec        <= NOP_VEC;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_tag   <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (r_state == QREQ_IDLE) begin
        if (w_pop) begin
          r_vec   <= w_head;
          r_state <= QREQ_WAIT;
        end
      end else if (cache_ack) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= cache_hit_miss;
        r_resp_tag   <= w_issue_tag;
        r_resp_data  <= cache_data;
        r_vec        <= NOP_VEC;
        r_state      <= QREQ_IDLE;
      end else if (w_expire) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= MISS;
        r_resp_tag   <= w_issue_tag;
        r_resp_data  <= '0;
        r_vec        <= NOP_VEC;
        r_state      <= QREQ_IDLE;
      end
    end
  end

  assign cache_vector_out = r_vec;
  assign resp_valid       = r_resp_valid;
  assign resp_hit         = r_resp_hit;
  assign resp_tag         = r_resp_tag;
  assign resp_data        = r_resp_data;

endmodule

// File: tb/tb_cache_request_queue.sv
// Bench for cache_request_queue: queue-based reference model checked every
// cycle plus literal checks; timeout cases run when CACHE_REQ_TIMEOUT_EN is set.
module tb_cache_request_queue;

  localparam int TW = 4, DW = 4, OW = 2, LW = 10, DEPTH = 4, PW = 2, TMO = 16;

  logic          clk, rst, req_valid, req_ready, cache_ack, cache_hit_miss;
  logic [OW-1:0] req_opcode;
  logic [TW-1:0] req_tag, resp_tag;
  logic [DW-1:0] req_data, cache_data, resp_data;
  logic [LW-1:0] cache_vector_out;
  logic          resp_valid, resp_hit, timeout_err;
  logic [PW:0]   queue_count;

  cache_request_queue #(
    .CACHE_TAG_WIDTH(TW), .CACHE_DATA_WIDTH(DW), .OPCODE_WIDTH(OW),
    .QUEUE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_tag(req_tag), .req_data(req_data),
    .cache_vector_out(cache_vector_out), .cache_ack(cache_ack),
    .cache_hit_miss(cache_hit_miss), .cache_data(cache_data),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_tag(resp_tag),
    .resp_data(resp_data), .queue_count(queue_count), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request list plus "one outstanding" bookkeeping.
  logic [LW-1:0] m_q[$];
  logic [LW-1:0] m_vec;
  bit            m_busy, m_rv, m_hit, m_terr;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  int            m_wait;
  logic [TW-1:0] got_tags[$];

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_vec = '0; m_busy = 0; m_rv = 0; m_hit = 0; m_terr = 0;
      m_tag = '0; m_data = '0; m_wait = 0;
    end else begin
      bit ready_now;
      ready_now = (m_q.size() < DEPTH);
      m_rv = 0;
      if (!m_busy) begin
        if (m_q.size() > 0) begin
          m_vec = m_q.pop_front(); m_busy = 1; m_wait = 0;
        end
      end else if (cache_ack) begin
        m_rv = 1; m_hit = cache_hit_miss; m_tag = m_vec[DW +: TW]; m_data = cache_data;
        m_vec = '0; m_busy = 0;
      end else begin
        m_wait++;
`ifdef CACHE_REQ_TIMEOUT_EN
        if (m_wait == TMO) begin
          m_rv = 1; m_hit = 0; m_tag = m_vec[DW +: TW]; m_data = '0;
          m_terr = 1; m_vec = '0; m_busy = 0;
        end
`endif
      end
      if (req_valid && ready_now && req_opcode != 2'b00)
        m_q.push_back({req_opcode, req_tag, req_data});
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("req_ready",   req_ready, m_q.size() < DEPTH);
    chk("queue_count", queue_count, m_q.size());
    chk("vector",      cache_vector_out, m_vec);
    chk("resp_valid",  resp_valid, m_rv);
    chk("resp_hit",    resp_hit, m_hit);
    chk("resp_tag",    resp_tag, m_tag);
    chk("resp_data",   resp_data, m_data);
    chk("timeout_err", timeout_err, m_terr);
    if (resp_valid) got_tags.push_back(resp_tag);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] tag, input logic [3:0] data);
    req_valid = 1; req_opcode = op; req_tag = tag; req_data = data;
    tick();
    req_valid = 0;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_opcode = 0; req_tag = 0; req_data = 0;
    cache_ack = 0; cache_hit_miss = 0; cache_data = 0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_count", queue_count, 0);
    chk("rst_vec",   cache_vector_out, 0);
    chk("rst_rv",    resp_valid, 0);
    chk("rst_terr",  timeout_err, 0);
    rst = 0;

    // Single READ: stored on edge 1, issued on edge 2, acked.
    push(2'b01, 4'h3, 4'h0);
    chk("t1_count1", queue_count, 1);
    chk("t1_vec_nop", cache_vector_out, 0);
    tick();
    chk("t1_vec", cache_vector_out, 10'b01_0011_0000);
    cache_ack = 1; cache_hit_miss = 1; cache_data = 4'hA;
    tick();
    cache_ack = 0;
    chk("t1_rv", resp_valid, 1);
    chk("t1_hit", resp_hit, 1);
    chk("t1_tag", resp_tag, 4'h3);
    chk("t1_data", resp_data, 4'hA);
    chk("t1_vec_back", cache_vector_out, 0);
    tick();
    chk("t1_rv_pulse", resp_valid, 0);
    chk("t1_data_hold", resp_data, 4'hA);

    // NOP is accepted but not stored.
    req_valid = 1; req_opcode = 2'b00; req_tag = 4'h5;
    chk("nop_ready", req_ready, 1);
    tick();
    req_valid = 0;
    chk("nop_count", queue_count, 0);
    tick();
    chk("nop_vec", cache_vector_out, 0);

    // Ack while idle is ignored.
    cache_ack = 1; cache_data = 4'h7;
    tick(); chk("idle_ack_rv0", resp_valid, 0);
    tick(); chk("idle_ack_rv1", resp_valid, 0);
    cache_ack = 0;

    // Five WRITEs with the cache stalled, then drain in order.
    got_tags.delete();
    for (int i = 0; i < 5; i++) push(2'b10, 4'(i), 4'(i + 5));
    chk("full_count", queue_count, 4);
    chk("full_ready", req_ready, 0);
    repeat (3) tick();
    chk("full_count_hold", queue_count, 4);
    chk("full_ready_hold", req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 10 && cache_vector_out == 0; k++) tick();
      chk("issue_wait", cache_vector_out != 0, 1);
      cache_ack = 1; cache_hit_miss = cache_vector_out[4]; cache_data = ~cache_vector_out[7:4];
      tick();
      cache_ack = 0;
    end
    tick();
    chk("drain_n", got_tags.size(), 5);
    for (int i = 0; i < 5 && i < got_tags.size(); i++) chk("drain_tag", got_tags[i], i);
    chk("drain_empty", queue_count, 0);

    // Reset in WAIT with two entries queued.
    push(2'b01, 4'hA, 4'h1);
    push(2'b01, 4'hB, 4'h2);
    push(2'b01, 4'hC, 4'h3);
    chk("pre_rst_count", queue_count, 2);
    rst = 1; tick(); rst = 0;
    chk("rst_mid_count", queue_count, 0);
    chk("rst_mid_vec", cache_vector_out, 0);
    chk("rst_mid_rv", resp_valid, 0);
    cache_ack = 1; tick(); cache_ack = 0;
    chk("rst_late_ack", resp_valid, 0);
    tick();
    chk("rst_late_vec", cache_vector_out, 0);

`ifdef CACHE_REQ_TIMEOUT_EN
    push(2'b01, 4'h6, 4'h9);
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("to_pre_rv", resp_valid, 0);
    tick();
    chk("to_rv", resp_valid, 1);
    chk("to_hit", resp_hit, 0);
    chk("to_data", resp_data, 0);
    chk("to_tag", resp_tag, 4'h6);
    chk("to_err", timeout_err, 1);
    repeat (3) tick();
    chk("to_err_sticky", timeout_err, 1);
    rst = 1; tick(); rst = 0;
    chk("to_err_clr", timeout_err, 0);
    push(2'b01, 4'h7, 4'h0);
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    cache_ack = 1; cache_hit_miss = 1; cache_data = 4'h5;
    tick();
    cache_ack = 0;
    chk("to_ack_rv", resp_valid, 1);
    chk("to_ack_hit", resp_hit, 1);
    chk("to_ack_data", resp_data, 4'h5);
    chk("to_ack_err", timeout_err, 0);
`else
    // Without the timeout, WAIT persists indefinitely.
    push(2'b01, 4'h6, 4'h9);
    for (int i = 0; i < TMO + 4; i++) tick();
    chk("nto_vec_held", cache_vector_out, 10'b01_0110_1001);
    chk("nto_err", timeout_err, 0);
    cache_ack = 1; cache_hit_miss = 0; cache_data = 4'h4;
    tick();
    cache_ack = 0;
    chk("nto_rv", resp_valid, 1);
    chk("nto_data", resp_data, 4'h4);
`endif
    tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
